// File: rtl/tri_mshr_arbiter.sv
// ----------------------------------------------------------------------------
// tri_mshr_arbiter
//
// Shares the single TRI request channel toward the L2 between SOURCE_NUM
// requesters. Each accepted request gets an MSHR id from a fixed pool and the
// owning source is recorded. L2 responses are routed back to their owner by id,
// after which the id returns to the pool.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   src_req_*        per-source request channel (valid/ready, packed payloads)
//   l2_req_*         single registered request channel toward the L2
//   l2_resp_*        L2 response (no backpressure)
//   src_resp_valid   one-hot response strobe, one cycle after the L2 response
//   src_resp_data    response data shared by all sources (holds last value)
//   outstanding_cnt  number of ids currently allocated
//   err_unknown_id   sticky flag: response carried an unallocated/out-of-range id
// ----------------------------------------------------------------------------
module tri_mshr_arbiter #(
    parameter int SOURCE_NUM = 2,
    parameter int MSHR_BASE  = 128,
    parameter int MSHR_NUM   = 16,
    parameter int ADDR_W     = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SOURCE_NUM-1:0]        src_req_valid,
    output logic [SOURCE_NUM-1:0]        src_req_ready,
    input  logic [SOURCE_NUM*ADDR_W-1:0] src_req_addr,
    input  logic [SOURCE_NUM*5-1:0]      src_req_type,
    input  logic [SOURCE_NUM*64-1:0]     src_req_data,
    output logic                         l2_req_valid,
    input  logic                         l2_req_ready,
    output logic [ADDR_W-1:0]            l2_req_addr,
    output logic [4:0]                   l2_req_type,
    output logic [63:0]                  l2_req_data,
    output logic [7:0]                   l2_req_mshrid,
    input  logic                         l2_resp_valid,
    input  logic [7:0]                   l2_resp_mshrid,
    input  logic [127:0]                 l2_resp_data,
    output logic [SOURCE_NUM-1:0]        src_resp_valid,
    output logic [127:0]                 src_resp_data,
    output logic [$clog2(MSHR_NUM):0]    outstanding_cnt,
    output logic                         err_unknown_id
);

    localparam int SRC_W = (SOURCE_NUM > 1) ? $clog2(SOURCE_NUM) : 1;
    localparam int IDX_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
    localparam int CNT_W = $clog2(MSHR_NUM) + 1;

    logic [SRC_W-1:0]        rr_ptr;
    logic [MSHR_NUM-1:0]     busy;
    logic [SRC_W-1:0]        owner [MSHR_NUM];

    logic [2*SOURCE_NUM-1:0] dbl_valid;
    logic [SOURCE_NUM-1:0]   rot_valid;
    logic [SRC_W-1:0]        winner;
    logic                    any_valid;
    int                      win_sum;
    logic [IDX_W-1:0]        free_idx;
    logic                    id_avail;
    logic                    can_load;
    logic                    accept;
    logic                    resp_in_range;
    logic [IDX_W-1:0]        resp_idx;
    logic                    resp_hit;

    // Round-robin search: rotate the valid vector so the RR pointer sits at
    // bit 0, take the first set bit, then map back to a source index.
    assign dbl_valid = {src_req_valid, src_req_valid};
    assign rot_valid = SOURCE_NUM'(dbl_valid >> rr_ptr);

    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        win_sum   = 0;
        for (int n = 0; n < SOURCE_NUM; n++) begin
            if (!any_valid && rot_valid[n]) begin
                any_valid = 1'b1;
                win_sum   = int'(rr_ptr) + n;
                if (win_sum >= SOURCE_NUM) win_sum = win_sum - SOURCE_NUM;
                winner    = SRC_W'(win_sum);
            end
        end
    end

    // Lowest free pool index. Uses the busy vector before this cycle's
    // response frees anything, so a same-cycle accept never reuses a freed id.
    always_comb begin
        free_idx = '0;
        id_avail = 1'b0;
        for (int j = 0; j < MSHR_NUM; j++) begin
            if (!id_avail && !busy[j]) begin
                id_avail = 1'b1;
                free_idx = IDX_W'(j);
            end
        end
    end

    assign can_load      = !l2_req_valid || l2_req_ready;
    assign accept        = can_load && id_avail && any_valid;
    assign src_req_ready = accept ? (SOURCE_NUM'(1) << winner) : '0;

    assign resp_in_range = (l2_resp_mshrid >= 8'(MSHR_BASE)) &&
                           ({1'b0, l2_resp_mshrid} < 9'(MSHR_BASE + MSHR_NUM));
    assign resp_idx      = IDX_W'(l2_resp_mshrid - 8'(MSHR_BASE));
    assign resp_hit      = l2_resp_valid && resp_in_range && busy[resp_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            l2_req_valid    <= 1'b0;
            l2_req_addr     <= '0;
            l2_req_type     <= '0;
            l2_req_data     <= '0;
            l2_req_mshrid   <= '0;
            src_resp_valid  <= '0;
            src_resp_data   <= '0;
            outstanding_cnt <= '0;
            err_unknown_id  <= 1'b0;
        end else begin
            if (accept) begin
                l2_req_valid  <= 1'b1;
                l2_req_addr   <= src_req_addr[winner*ADDR_W +: ADDR_W];
                l2_req_type   <= src_req_type[winner*5 +: 5];
                l2_req_data   <= src_req_data[winner*64 +: 64];
                l2_req_mshrid <= 8'(MSHR_BASE) + 8'(free_idx);
                rr_ptr        <= (winner == SRC_W'(SOURCE_NUM - 1)) ? '0 : winner + 1'b1;
            end else if (l2_req_ready) begin
                l2_req_valid  <= 1'b0;
            end

            src_resp_valid <= resp_hit ? (SOURCE_NUM'(1) << owner[resp_idx]) : '0;
            if (resp_hit) src_resp_data <= l2_resp_data;

            if (l2_resp_valid && !resp_hit) err_unknown_id <= 1'b1;

            if (accept && !resp_hit)      outstanding_cnt <= outstanding_cnt + CNT_W'(1);
            else if (!accept && resp_hit) outstanding_cnt <= outstanding_cnt - CNT_W'(1);
        end
    end

    // Pool bookkeeping. The freed index and the allocated index can never be
    // the same entry: one is busy and the other free before the edge.
    // NOTE: the owner table is a small register array, so it is cleared on
    // reset along with the busy bits; a late response after reset must never
    // see stale ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int j = 0; j < MSHR_NUM; j++) owner[j] <= '0;
        end else begin
            if (resp_hit) busy[resp_idx] <= 1'b0;
            if (accept) begin
                busy[free_idx]  <= 1'b1;
                owner[free_idx] <= winner;
            end
        end
    end

endmodule
